pwm_bank: RTL and testbench

- Parametrised multi-channel PWM generator for the LED and GPIO outputs.
- Replaces per-channel pwm instances, which each had their own counter and fixed compare values.
- All channels share one prescaler and one period counter.
- Each channel has a host-writable duty register, double-buffered so that new values take effect only at a period boundary.
- Supports edge-aligned and center-aligned modes. The UART receive path or another control block writes duties through a simple write strobe.

---
 rtl/pwm_pkg.sv | 15 +
 rtl/pwm_timebase.sv | 103 ++++++++++
 rtl/pwm_bank.sv | 112 +++++++++++
 tb/tb_pwm_bank.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM bank.
//   pwm_mode_e : edge-aligned or center-aligned counting
//   ch_idx_w() : width of a channel index (at least one bit)
package pwm_pkg;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler, period counter, count direction and
// period-boundary generation.
// Ports:
//   clk, reset_n   : clock, synchronous active-low reset
//   enable         : run (1) / hold counters at their reset values (0)
//   div            : prescaler divide (0 behaves as 1)
//   top            : period counter terminal value
//   mode           : requested mode, latched at each boundary
//   cnt            : registered period counter
//   boundary_c     : combinational, high in the tick that ends a period
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int unsigned PWM_BITS  = 8,
  parameter int unsigned DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic [PWM_BITS-1:0]  top,
  input  pwm_mode_e            mode,
  output logic [PWM_BITS-1:0]  cnt,
  output logic                 boundary_c
);

  logic [DIV_WIDTH-1:0] r_pre_cnt;
  logic [DIV_WIDTH-1:0] w_pre_term;
  logic [PWM_BITS-1:0]  r_cnt;
  logic [PWM_BITS-1:0]  w_cnt_nxt;
  logic                 r_dir_down;
  logic                 w_dir_nxt;
  logic                 w_tick;
  logic                 w_wrap;
  pwm_mode_e            r_mode_q;

  // Prescaler terminal; >= guards against div being lowered mid-count.
  assign w_pre_term = (div == '0) ? '0 : div - DIV_WIDTH'(1);
  assign w_tick     = (r_pre_cnt >= w_pre_term);

  // Next count / direction and period wrap for the latched mode.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_dir_nxt = r_dir_down;
    w_wrap    = 1'b0;
    if (w_tick) begin
      if (r_mode_q == PWM_EDGE) begin
        if (r_cnt >= top) begin
          w_cnt_nxt = '0;
          w_wrap    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + PWM_BITS'(1);
        end
      end else if (top == '0) begin
        // Degenerate center period: one boundary per tick.
        w_cnt_nxt = '0;
        w_dir_nxt = 1'b0;
        w_wrap    = 1'b1;
      end else if (!r_dir_down) begin
        if (r_cnt >= top) begin
          w_cnt_nxt = top - PWM_BITS'(1);
          w_dir_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + PWM_BITS'(1);
        end
      end else begin
        if (r_cnt <= PWM_BITS'(1)) begin
          w_cnt_nxt = '0;
          w_dir_nxt = 1'b0;
          w_wrap    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - PWM_BITS'(1);
        end
      end
    end
  end

  // Counter state; held cleared while disabled, mode tracks input then.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pre_cnt  <= '0;
      r_cnt      <= '0;
      r_dir_down <= 1'b0;
      r_mode_q   <= PWM_EDGE;
    end else if (!enable) begin
      r_pre_cnt  <= '0;
      r_cnt      <= '0;
      r_dir_down <= 1'b0;
      r_mode_q   <= mode;
    end else begin
      r_pre_cnt  <= w_tick ? '0 : r_pre_cnt + DIV_WIDTH'(1);
      r_cnt      <= w_cnt_nxt;
      r_dir_down <= w_dir_nxt;
      if (w_wrap) begin
        r_mode_q <= mode;
      end
    end
  end

  assign cnt        = r_cnt;
  assign boundary_c = enable & w_wrap;

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM generator sharing one timebase. Each channel has a
// host-written shadow duty copied to its active duty at period boundaries
// (and continuously while disabled).
// Optional feature macro: PWM_POLARITY_EN adds a per-channel polarity input,
// latched like the duties, which inverts the output and sets the idle level.
// Ports:
//   clk, reset_n     : clock, synchronous active-low reset
//   enable           : run (1) / halt and clear (0)
//   div, top, mode   : timebase configuration
//   wr_en/ch/duty    : duty write strobe, channel index and value
//   polarity         : (PWM_POLARITY_EN only) per-channel output inversion
//   pwm_o            : registered PWM outputs
//   period_o         : one-clock pulse after each period boundary
module pwm_bank
  import pwm_pkg::*;
#(
  parameter  int unsigned NUM_CH    = 8,
  parameter  int unsigned PWM_BITS  = 8,
  parameter  int unsigned DIV_WIDTH = 8,
  localparam int unsigned CH_W      = ch_idx_w(NUM_CH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic [PWM_BITS-1:0]  top,
  input  pwm_mode_e            mode,
  input  logic                 wr_en,
  input  logic [CH_W-1:0]      wr_ch,
  input  logic [PWM_BITS-1:0]  wr_duty,
`ifdef PWM_POLARITY_EN
  input  logic [NUM_CH-1:0]    polarity,
`endif
  output logic [NUM_CH-1:0]    pwm_o,
  output logic                 period_o
);

  logic [PWM_BITS-1:0] w_cnt;
  logic                w_boundary;
  logic [NUM_CH-1:0]   w_raw;
  logic [NUM_CH-1:0]   w_pol;

  pwm_timebase #(
    .PWM_BITS  (PWM_BITS),
    .DIV_WIDTH (DIV_WIDTH)
  ) u_timebase (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .div        (div),
    .top        (top),
    .mode       (mode),
    .cnt        (w_cnt),
    .boundary_c (w_boundary)
  );

  // Per-channel shadow/active duty and compare.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [PWM_BITS-1:0] r_shadow;
    logic [PWM_BITS-1:0] r_active;

    // Out-of-range wr_ch never matches any channel index.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        r_shadow <= '0;
        r_active <= '0;
      end else begin
        if (wr_en && (wr_ch == CH_W'(i))) begin
          r_shadow <= wr_duty;
        end
        if (!enable || w_boundary) begin
          r_active <= r_shadow;
        end
      end
    end

    // All-ones duty is a full-on level even when top is all-ones.
    assign w_raw[i] = (r_active == '1) | (r_active > w_cnt);
  end

`ifdef PWM_POLARITY_EN
  logic [NUM_CH-1:0] r_pol_q;

  // Polarity follows the duty load timing.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pol_q <= '0;
    end else if (!enable || w_boundary) begin
      r_pol_q <= polarity;
    end
  end

  assign w_pol = r_pol_q;
`else
  assign w_pol = '0;
`endif

  // Output pins: idle level while disabled, one clock after cnt otherwise.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pwm_o    <= '0;
      period_o <= 1'b0;
    end else if (!enable) begin
      pwm_o    <= w_pol;
      period_o <= 1'b0;
    end else begin
      pwm_o    <= w_raw ^ w_pol;
      period_o <= w_boundary;
    end
  end

endmodule

// File: tb/tb_pwm_bank.sv
// Scoreboard bench for pwm_bank: stimulus pushes cycle-tagged expected
// outputs, a negedge monitor pops and compares them.
module tb_pwm_bank;
  import pwm_pkg::*;

  localparam int unsigned NCH = 6;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             enable;
  logic [7:0]       div;
  logic [7:0]       top;
  pwm_mode_e        mode;
  logic             wr_en;
  logic [2:0]       wr_ch;
  logic [7:0]       wr_duty;
  logic [NCH-1:0]   polarity = '0;
  logic [NCH-1:0]   pwm_o;
  logic             period_o;

  typedef struct {
    int             cyc;
    int             sid;
    logic [NCH-1:0] pwm;
    logic           per;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   s0       = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  pwm_bank #(
    .NUM_CH    (NCH),
    .PWM_BITS  (8),
    .DIV_WIDTH (8)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .div      (div),
    .top      (top),
    .mode     (mode),
    .wr_en    (wr_en),
    .wr_ch    (wr_ch),
    .wr_duty  (wr_duty),
`ifdef PWM_POLARITY_EN
    .polarity (polarity),
`endif
    .pwm_o    (pwm_o),
    .period_o (period_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation tagged for the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      if (e.cyc != cyc || pwm_o !== e.pwm || period_o !== e.per) begin
        n_fail++;
        $display("FAIL sc%0d cyc %0d (due %0d): pwm_o=%b period_o=%b, expected pwm_o=%b period_o=%b",
                 e.sid, cyc, e.cyc, pwm_o, period_o, e.pwm, e.per);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // k = 0 is the output right after the first edge that samples enable=1.
  task automatic push(input int sid, input int k, input logic [NCH-1:0] p, input logic per);
    exp_t e;
    e.cyc = s0 + 1 + k;
    e.sid = sid;
    e.pwm = p;
    e.per = per;
    sb.push_back(e);
  endtask

  task automatic wr(input logic [2:0] ch, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_ch   = ch;
    wr_duty = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic restart();
    reset_n = 1'b0;
    enable  = 1'b0;
    wr_en   = 1'b0;
    div     = 8'd1;
    top     = 8'd9;
    mode    = PWM_EDGE;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic go();
    enable = 1'b1;
    s0     = cyc;
  endtask

  // Edge mode, top=9, ch0=3, ch1=0 at the given divide.
  task automatic sc_edge(input int sid, input logic [7:0] dv);
    logic [NCH-1:0] p;
    restart();
    div = dv;
    wr(3'd0, 8'd3);
    wr(3'd1, 8'd0);
    repeat (2) tick();
    go();
    for (int k = 0; k < 30; k++) begin
      p = '0;
      p[0] = ((k % 10) < 3);
      push(sid, k, p, (k % 10) == 9);
    end
    repeat (30) tick();
  endtask

  initial begin
    logic [NCH-1:0] p;
    int             c;
    int             d;
    int             k2;

    // Reset state, even with enable high.
    reset_n = 1'b0;
    enable  = 1'b1;
    wr_en   = 1'b0;
    wr_ch   = '0;
    wr_duty = '0;
    div     = 8'd1;
    top     = 8'd9;
    mode    = PWM_EDGE;
    tick();
    s0 = cyc;
    push(0, 0, '0, 1'b0);
    push(0, 1, '0, 1'b0);
    repeat (3) tick();

    // Edge period at div=1, then div=0 behaving identically.
    sc_edge(1, 8'd1);
    sc_edge(2, 8'd0);

    // Saturation: all-ones duty with top=255.
    restart();
    top = 8'd255;
    wr(3'd2, 8'd255);
    repeat (2) tick();
    go();
    for (int k = 0; k < 16; k++) push(3, k, 6'b000100, 1'b0);
    repeat (16) tick();

    // Saturation: all-ones and duty > top with top=9.
    restart();
    wr(3'd2, 8'd255);
    wr(3'd3, 8'd12);
    repeat (2) tick();
    go();
    for (int k = 0; k < 20; k++) push(4, k, 6'b001100, (k % 10) == 9);
    repeat (20) tick();

    // Double buffering: mid-period writes (last wins), boundary-cycle write.
    restart();
    wr(3'd0, 8'd3);
    repeat (2) tick();
    go();
    for (int k = 0; k < 30; k++) begin
      d = (k < 10) ? 3 : (k < 20) ? 7 : 5;
      p = '0;
      p[0] = ((k % 10) < d);
      push(5, k, p, (k % 10) == 9);
    end
    repeat (3) tick();
    wr(3'd0, 8'd6);
    wr(3'd0, 8'd7);
    repeat (4) tick();
    wr(3'd0, 8'd5);
    repeat (20) tick();

    // Center mode: top=4, div=2, ch0=2 -> 16-clock period, 6 clocks high.
    restart();
    mode = PWM_CENTER;
    top  = 8'd4;
    div  = 8'd2;
    wr(3'd0, 8'd2);
    repeat (2) tick();
    go();
    for (int k = 0; k < 40; k++) begin
      p = '0;
      p[0] = ((k % 16) < 4) || ((k % 16) >= 14);
      push(6, k, p, (k % 16) == 15);
    end
    repeat (40) tick();

    // Lowering top 9 -> 2 while cnt=6 wraps on the next tick.
    restart();
    wr(3'd0, 8'd2);
    repeat (2) tick();
    go();
    for (int k = 0; k < 24; k++) begin
      c = (k <= 6) ? k : ((k - 7) % 3);
      p = '0;
      p[0] = (c < 2);
      push(7, k, p, (k >= 6) && (((k - 6) % 3) == 0));
    end
    repeat (6) tick();
    top = 8'd2;
    repeat (18) tick();

    // Reset mid-period: outputs clear at once, duties stay cleared.
    restart();
    wr(3'd0, 8'd3);
    repeat (2) tick();
    go();
    for (int k = 0; k < 30; k++) begin
      p = '0;
      if (k < 11) p[0] = ((k % 10) < 3);
      push(8, k, p, (k == 9) || (k == 22));
    end
    repeat (11) tick();
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (17) tick();

    // Disable, write ch1=5 while halted, re-enable: first period uses it.
    restart();
    wr(3'd0, 8'd3);
    repeat (2) tick();
    go();
    for (int k = 0; k < 30; k++) begin
      p = '0;
      if (k < 5) begin
        p[0] = (k < 3);
        push(9, k, p, 1'b0);
      end else if (k < 9) begin
        push(9, k, p, 1'b0);
      end else begin
        k2 = k - 9;
        p[0] = ((k2 % 10) < 3);
        p[1] = ((k2 % 10) < 5);
        push(9, k, p, (k2 % 10) == 9);
      end
    end
    repeat (5) tick();
    enable = 1'b0;
    tick();
    wr(3'd1, 8'd5);
    repeat (2) tick();
    enable = 1'b1;
    repeat (21) tick();

    // Out-of-range channel writes change nothing.
    restart();
    wr(3'd0, 8'd3);
    repeat (2) tick();
    go();
    for (int k = 0; k < 30; k++) begin
      p = '0;
      p[0] = ((k % 10) < 3);
      push(10, k, p, (k % 10) == 9);
    end
    repeat (3) tick();
    wr(3'd6, 8'd200);
    wr(3'd7, 8'd9);
    repeat (25) tick();

    repeat (2) tick();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
